// File: rtl/sccb_cfg_pkg.sv
// Shared types and table markers for the SCCB configuration sequencer.
package sccb_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } sccb_cfg_state_e;

  // One table entry: register address followed by register data.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_cfg_entry_t;

  localparam logic [15:0] SCCB_CFG_END        = 16'hFFFF;
  localparam logic [7:0]  SCCB_CFG_DELAY_ADDR = 8'hF0;

endpackage

// File: rtl/sccb_cfg_rom.sv
// Camera register table with a registered output (entry valid one clock after index).
module sccb_cfg_rom
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 64,
  localparam int unsigned ROM_AW = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROM_AW-1:0]     index,
  output sccb_cfg_entry_t       entry
);

  sccb_cfg_entry_t entry_c;

  // Register list; unlisted slots read as end of table.
  always_comb begin
    entry_c = SCCB_CFG_END;
    case (index)
      ROM_AW'(0): entry_c = '{addr: 8'h12, data: 8'h80};
      ROM_AW'(1): entry_c = '{addr: SCCB_CFG_DELAY_ADDR, data: 8'h00};
      ROM_AW'(2): entry_c = '{addr: 8'h11, data: 8'h01};
      ROM_AW'(3): entry_c = SCCB_CFG_END;
      default:    entry_c = SCCB_CFG_END;
    endcase
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else begin
      entry <= entry_c;
    end
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera register table and issues one SCCB write per entry.
// Optional feature: define SCCB_CFG_RETRY_EN to retry a failed write up to RETRY_MAX times.
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned ROM_DEPTH      = 64,
  parameter int unsigned SETTLE_CYCLES  = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter int unsigned RETRY_MAX      = 3,
  localparam int unsigned ROM_AW = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index,
  output logic              sccb_transmit,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_write_data,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  input  logic              sccb_nack
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DLY_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ROM_AW-1:0] LAST_INDEX = ROM_AW'(ROM_DEPTH - 1);

  sccb_cfg_state_e  state;
  logic [ROM_AW-1:0] index;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  sccb_cfg_entry_t   rom_entry;
  logic              fail_c;
  logic              retry_ok_c;

  sccb_cfg_rom #(
    .ROM_DEPTH (ROM_DEPTH)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .index (index),
    .entry (rom_entry)
  );

  // A write fails on a NACKed completion or when the wait budget runs out.
  assign fail_c = sccb_done ? sccb_nack : (tmo_cnt == '0);

`ifdef SCCB_CFG_RETRY_EN
  localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RETRY_W-1:0] retry_cnt;

  assign retry_ok_c = (retry_cnt < RETRY_W'(RETRY_MAX));

  // Retries used on the current entry; cleared whenever a new entry is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (state == ST_DECODE) begin
      retry_cnt <= '0;
    end else if (state == ST_WAIT && fail_c && retry_ok_c) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end
`else
  assign retry_ok_c = 1'b0;
`endif

  // Sequencer FSM with registered status and bus request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      index           <= '0;
      tmo_cnt         <= '0;
      dly_cnt         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_index       <= '0;
      sccb_transmit   <= 1'b0;
      sccb_address    <= '0;
      sccb_write_data <= '0;
    end else begin
      sccb_transmit <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            index <= '0;
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (16'(rom_entry) == SCCB_CFG_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (rom_entry.addr == SCCB_CFG_DELAY_ADDR) begin
            dly_cnt <= DLY_W'(SETTLE_CYCLES - 1);
            state   <= ST_DELAY;
          end else begin
            sccb_address    <= rom_entry.addr;
            sccb_write_data <= rom_entry.data;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!sccb_busy) begin
            sccb_transmit <= 1'b1;
            tmo_cnt       <= TMO_W'(TIMEOUT_CYCLES - 1);
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sccb_done && !sccb_nack) begin
            state <= ST_NEXT;
          end else if (fail_c) begin
            if (retry_ok_c) begin
              state <= ST_ISSUE;
            end else begin
              error     <= 1'b1;
              err_index <= index;
              busy      <= 1'b0;
              state     <= ST_ERROR;
            end
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        ST_DELAY: begin
          if (dly_cnt == '0) begin
            state <= ST_NEXT;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end
        ST_NEXT: begin
          if (index == LAST_INDEX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            index <= index + ROM_AW'(1);
            state <= ST_FETCH;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
